// File: rtl/gemm_pkg.sv
// Shared definitions for the tiled GEMM sequencer.
// Contents:
//   seq_state_t   - sequencer FSM states
//   ceil_div      - integer ceiling division
//   calc_k        - im2col row count (IC * KERNEL_SIZE^2)
//   calc_k_tiles  - number of K-tiles for a given SA dimension
//   calc_n_tiles  - number of N-tiles (output-channel tiles)
//   lane_mask     - valid-lane mask for a partially filled tile
package gemm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_OUT,
    ST_FIN
  } seq_state_t;

  // Widest SA the lane-mask helper can describe; callers truncate to PE_SIZE.
  localparam int MAX_LANES = 64;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int calc_k(input int ic, input int kernel_size);
    return ic * kernel_size * kernel_size;
  endfunction

  function automatic int calc_k_tiles(input int ic, input int kernel_size, input int pe_size);
    return ceil_div(calc_k(ic, kernel_size), pe_size);
  endfunction

  function automatic int calc_n_tiles(input int oc, input int pe_size);
    return ceil_div(oc, pe_size);
  endfunction

  // Bit i set iff lane i exists in the array and base+i is still inside the
  // real dimension; lanes past the end of a partial tile are masked off.
  function automatic logic [MAX_LANES-1:0] lane_mask(input int base, input int total,
                                                     input int lanes);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      m[i] = (i < lanes) && (base + i < total);
    end
    return m;
  endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift line that carries per-row write tags alongside the
// systolic array so the accumulator write lines up with its psum.
// Ports:
//   clk      - clock
//   clr      - synchronous clear of every stage (drops in-flight tags)
//   push_tag - tag entering the line this cycle
//   pop_tag  - tag that entered DEPTH cycles ago
module tag_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] push_tag,
  output logic [WIDTH-1:0] pop_tag
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("tag_delay_line: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stage_p [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
    end else begin
      stage_p[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign pop_tag = stage_p[DEPTH-1];

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Controller for one tiled convolution-as-GEMM pass over the systolic array.
// Walks N-tiles (output channels) outer and K-tiles (im2col rows) inner; per
// K-tile it preloads weights, streams M_ROWS ifmap columns and waits for the
// array to drain, then after the last K-tile drains the accumulator.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start_i         - begin a pass (honoured only when idle)
//   stall_i         - freeze weight/ifmap issue
//   out_ready_i     - downstream accepts an accumulator read
//   busy_o, done_o  - pass in progress / one-cycle end-of-pass pulse
//   w_rden_o, w_addr_o, weight_load_o     - weight buffer read, SA preload
//   w_row_mask_o, w_col_mask_o            - valid K / OC lanes of this tile
//   if_rden_o, if_addr_o                  - ifmap buffer read
//   acc_wren_o, acc_wr_addr_o, acc_first_o - delay-aligned ACC write
//   acc_rden_o, acc_rd_addr_o             - ACC drain read
module gemm_tile_sequencer
  import gemm_pkg::*;
#(
  parameter int PE_SIZE        = 14,
  parameter int IC             = 32,
  parameter int OC             = 64,
  parameter int KERNEL_SIZE    = 3,
  parameter int M_ROWS         = 196,
  parameter int SA_LATENCY     = 2 * PE_SIZE,
  parameter int W_ADDR_WIDTH   = 16,
  parameter int IF_ADDR_WIDTH  = 16,
  parameter int ACC_ADDR_WIDTH = $clog2(M_ROWS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      stall_i,
  input  logic                      out_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      w_rden_o,
  output logic [W_ADDR_WIDTH-1:0]   w_addr_o,
  output logic                      weight_load_o,
  output logic [PE_SIZE-1:0]        w_row_mask_o,
  output logic [PE_SIZE-1:0]        w_col_mask_o,
  output logic                      if_rden_o,
  output logic [IF_ADDR_WIDTH-1:0]  if_addr_o,
  output logic                      acc_wren_o,
  output logic [ACC_ADDR_WIDTH-1:0] acc_wr_addr_o,
  output logic                      acc_first_o,
  output logic                      acc_rden_o,
  output logic [ACC_ADDR_WIDTH-1:0] acc_rd_addr_o
);

  localparam int K       = calc_k(IC, KERNEL_SIZE);
  localparam int K_TILES = calc_k_tiles(IC, KERNEL_SIZE, PE_SIZE);
  localparam int N_TILES = calc_n_tiles(OC, PE_SIZE);
  localparam int TAG_W   = ACC_ADDR_WIDTH + 2;

  localparam longint W_ADDR_MAX  = longint'(N_TILES) * K_TILES * PE_SIZE - 1;
  localparam longint IF_ADDR_MAX = longint'(K_TILES) * M_ROWS - 1;

  if (W_ADDR_MAX >= (longint'(1) << W_ADDR_WIDTH)) begin : g_w_addr_chk
    $error("gemm_tile_sequencer: weight addresses exceed W_ADDR_WIDTH");
  end
  if (IF_ADDR_MAX >= (longint'(1) << IF_ADDR_WIDTH)) begin : g_if_addr_chk
    $error("gemm_tile_sequencer: ifmap addresses exceed IF_ADDR_WIDTH");
  end
  if (PE_SIZE > MAX_LANES) begin : g_lane_chk
    $error("gemm_tile_sequencer: PE_SIZE wider than lane_mask supports");
  end

  seq_state_t state, state_d;
  logic [31:0] beat, beat_d;
  logic [31:0] n_idx, n_d;
  logic [31:0] k_idx, k_d;
  logic        w_rden_p1;

  logic [ACC_ADDR_WIDTH-1:0] tag_addr;
  logic                      tag_first;
  logic [TAG_W-1:0]          push_tag, pop_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat      <= '0;
      n_idx     <= '0;
      k_idx     <= '0;
      w_rden_p1 <= 1'b0;
    end else begin
      state     <= state_d;
      beat      <= beat_d;
      n_idx     <= n_d;
      k_idx     <= k_d;
      w_rden_p1 <= w_rden_o;
    end
  end

  always_comb begin
    state_d       = state;
    beat_d        = beat;
    n_d           = n_idx;
    k_d           = k_idx;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    w_rden_o      = 1'b0;
    w_addr_o      = '0;
    if_rden_o     = 1'b0;
    if_addr_o     = '0;
    acc_rden_o    = 1'b0;
    acc_rd_addr_o = '0;
    tag_addr      = '0;
    tag_first     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_W_LOAD;
          beat_d  = '0;
          n_d     = '0;
          k_d     = '0;
        end
      end
      ST_W_LOAD: begin
        busy_o = 1'b1;
        if (!stall_i) begin
          w_rden_o = 1'b1;
          w_addr_o = W_ADDR_WIDTH'((n_idx * K_TILES + k_idx) * PE_SIZE + beat);
          if (beat == PE_SIZE - 1) begin
            beat_d  = '0;
            state_d = ST_STREAM;
          end else begin
            beat_d = beat + 32'd1;
          end
        end
      end
      ST_STREAM: begin
        busy_o = 1'b1;
        if (!stall_i) begin
          if_rden_o = 1'b1;
          if_addr_o = IF_ADDR_WIDTH'(k_idx * M_ROWS + beat);
          tag_addr  = ACC_ADDR_WIDTH'(beat);
          tag_first = (k_idx == 0);
          if (beat == M_ROWS - 1) begin
            beat_d  = '0;
            state_d = ST_DRAIN;
          end else begin
            beat_d = beat + 32'd1;
          end
        end
      end
      ST_DRAIN: begin
        // Wait until the last streamed row has left the tag line so the next
        // weight preload cannot disturb psums still in the array.
        busy_o = 1'b1;
        if (beat == SA_LATENCY - 1) begin
          beat_d = '0;
          if (k_idx == K_TILES - 1) begin
            state_d = ST_OUT;
          end else begin
            k_d     = k_idx + 32'd1;
            state_d = ST_W_LOAD;
          end
        end else begin
          beat_d = beat + 32'd1;
        end
      end
      ST_OUT: begin
        busy_o        = 1'b1;
        acc_rden_o    = out_ready_i;
        acc_rd_addr_o = ACC_ADDR_WIDTH'(beat);
        if (out_ready_i) begin
          if (beat == M_ROWS - 1) begin
            beat_d = '0;
            k_d    = '0;
            if (n_idx == N_TILES - 1) begin
              state_d = ST_FIN;
            end else begin
              n_d     = n_idx + 32'd1;
              state_d = ST_W_LOAD;
            end
          end else begin
            beat_d = beat + 32'd1;
          end
        end
      end
      ST_FIN: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign weight_load_o = w_rden_p1;

  assign w_row_mask_o = busy_o ? PE_SIZE'(lane_mask(k_idx * PE_SIZE, K, PE_SIZE)) : '0;
  assign w_col_mask_o = busy_o ? PE_SIZE'(lane_mask(n_idx * PE_SIZE, OC, PE_SIZE)) : '0;

  // Stage p0..p(SA_LATENCY-1): tag {valid, row, first} rides with the psum
  assign push_tag = {if_rden_o, tag_addr, tag_first};

  tag_delay_line #(
    .DEPTH (SA_LATENCY),
    .WIDTH (TAG_W)
  ) u_tag_line (
    .clk      (clk),
    .clr      (rst),
    .push_tag (push_tag),
    .pop_tag  (pop_tag)
  );

  assign {acc_wren_o, acc_wr_addr_o, acc_first_o} = pop_tag;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
module tb_gemm_tile_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b, stall, out_ready;

  logic        a_busy, a_done, a_w_rden, a_weight_load, a_if_rden;
  logic        a_acc_wren, a_acc_first, a_acc_rden;
  logic [15:0] a_w_addr, a_if_addr;
  logic [3:0]  a_row, a_col;
  logic [1:0]  a_acc_wr_addr, a_acc_rd_addr;

  logic        b_busy, b_done, b_w_rden, b_weight_load, b_if_rden;
  logic        b_acc_wren, b_acc_first, b_acc_rden;
  logic [15:0] b_w_addr, b_if_addr;
  logic [3:0]  b_row, b_col;
  logic [1:0]  b_acc_wr_addr, b_acc_rd_addr;

  // A: K=2 (one K-tile), B: K=5 (two K-tiles); both OC=6 -> two N-tiles
  gemm_tile_sequencer #(
    .PE_SIZE(4), .IC(2), .OC(6), .KERNEL_SIZE(1), .M_ROWS(3), .SA_LATENCY(8)
  ) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .stall_i(stall), .out_ready_i(out_ready),
    .busy_o(a_busy), .done_o(a_done), .w_rden_o(a_w_rden), .w_addr_o(a_w_addr),
    .weight_load_o(a_weight_load), .w_row_mask_o(a_row), .w_col_mask_o(a_col),
    .if_rden_o(a_if_rden), .if_addr_o(a_if_addr), .acc_wren_o(a_acc_wren),
    .acc_wr_addr_o(a_acc_wr_addr), .acc_first_o(a_acc_first),
    .acc_rden_o(a_acc_rden), .acc_rd_addr_o(a_acc_rd_addr)
  );

  gemm_tile_sequencer #(
    .PE_SIZE(4), .IC(5), .OC(6), .KERNEL_SIZE(1), .M_ROWS(3), .SA_LATENCY(8)
  ) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .stall_i(stall), .out_ready_i(out_ready),
    .busy_o(b_busy), .done_o(b_done), .w_rden_o(b_w_rden), .w_addr_o(b_w_addr),
    .weight_load_o(b_weight_load), .w_row_mask_o(b_row), .w_col_mask_o(b_col),
    .if_rden_o(b_if_rden), .if_addr_o(b_if_addr), .acc_wren_o(b_acc_wren),
    .acc_wr_addr_o(b_acc_wr_addr), .acc_first_o(b_acc_first),
    .acc_rden_o(b_acc_rden), .acc_rd_addr_o(b_acc_rd_addr)
  );

  logic a_any;
  assign a_any = a_busy | a_done | a_w_rden | a_weight_load | a_if_rden | a_acc_wren |
                 a_acc_first | a_acc_rden | (|a_w_addr) | (|a_if_addr) | (|a_row) |
                 (|a_col) | (|a_acc_wr_addr) | (|a_acc_rd_addr);

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Event logs sampled mid-cycle
  int   cyc = 0;
  int   a_busy_cnt, a_done_cnt, a_wl_err;
  logic a_prev_wr = 1'b0;
  int   a_wa_q[$], a_ia_q[$], a_ic_q[$], a_aw_q[$], a_af_q[$], a_wc_q[$], a_ar_q[$];
  int   a_rm_q[$], a_cm_q[$];
  int   b_busy_cnt;
  int   b_wa_q[$], b_ia_q[$], b_af_q[$], b_rm_q[$];

  always @(negedge clk) begin
    cyc++;
    if (a_busy) a_busy_cnt++;
    if (a_done) a_done_cnt++;
    if (a_weight_load !== a_prev_wr) a_wl_err++;
    a_prev_wr = a_w_rden;
    if (a_w_rden) begin
      a_wa_q.push_back(int'(a_w_addr));
      a_rm_q.push_back(int'(a_row));
      a_cm_q.push_back(int'(a_col));
    end
    if (a_if_rden) begin
      a_ia_q.push_back(int'(a_if_addr));
      a_ic_q.push_back(cyc);
    end
    if (a_acc_wren) begin
      a_aw_q.push_back(int'(a_acc_wr_addr));
      a_af_q.push_back(int'(a_acc_first));
      a_wc_q.push_back(cyc);
    end
    if (a_acc_rden) a_ar_q.push_back(int'(a_acc_rd_addr));
    if (b_busy) b_busy_cnt++;
    if (b_w_rden) begin
      b_wa_q.push_back(int'(b_w_addr));
      b_rm_q.push_back(int'(b_row));
    end
    if (b_if_rden) b_ia_q.push_back(int'(b_if_addr));
    if (b_acc_wren) b_af_q.push_back(int'(b_acc_first));
  end

  task automatic clear_logs();
    a_busy_cnt = 0; a_done_cnt = 0; a_wl_err = 0; b_busy_cnt = 0;
    a_wa_q.delete(); a_ia_q.delete(); a_ic_q.delete(); a_aw_q.delete();
    a_af_q.delete(); a_wc_q.delete(); a_ar_q.delete(); a_rm_q.delete();
    a_cm_q.delete(); b_wa_q.delete(); b_ia_q.delete(); b_af_q.delete(); b_rm_q.delete();
  endtask

  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget);
    int n = 0;
    while (!(sel ? b_done : a_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sel) begin
      check("b_done_seen", 32'(b_done), 1);
      check("b_busy_low_at_done", 32'(b_busy), 0);
    end else begin
      check("a_done_seen", 32'(a_done), 1);
      check("a_busy_low_at_done", 32'(a_busy), 0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_a_event(input bit want_rd, input int budget);
    int n = 0;
    while (!(want_rd ? a_acc_rden : a_if_rden) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("a_event_seen", 32'(want_rd ? a_acc_rden : a_if_rden), 1);
  endtask

  // Streams common to every uninterrupted A pass: 6 ifmap reads, 6 first-writes
  // each 8 cycles after its read, 6 drain reads in row order.
  task automatic check_a_streams(input string s);
    check({s, "_if_count"}, a_ia_q.size(), 6);
    check({s, "_wr_count"}, a_aw_q.size(), 6);
    check({s, "_rd_count"}, a_ar_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check({s, "_if_addr"}, a_ia_q[i], i % 3);
      check({s, "_wr_addr"}, a_aw_q[i], i % 3);
      check({s, "_wr_first"}, a_af_q[i], 1);
      check({s, "_wr_delay"}, a_wc_q[i] - a_ic_q[i], 8);
      check({s, "_rd_addr"}, a_ar_q[i], i % 3);
    end
    check({s, "_wload_align"}, a_wl_err, 0);
    check({s, "_done_count"}, a_done_cnt, 1);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; stall = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_a_outputs_zero", 32'(a_any), 0);
    check("rst_b_busy", 32'(b_busy), 0);
    check("rst_b_row_mask", 32'(b_row), 0);

    // Full pass, no stall
    clear_logs();
    pulse_start(1'b0);
    wait_done(1'b0, 200);
    check("s1_busy_cycles", a_busy_cnt, 36);
    check("s1_w_count", a_wa_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("s1_w_addr", a_wa_q[i], i);
      check("s1_row_mask", a_rm_q[i], 3);
      check("s1_col_mask", a_cm_q[i], (i < 4) ? 15 : 3);
    end
    check_a_streams("s1");
    check("s1_idle_row_mask", 32'(a_row), 0);

    // Multi-K accumulate
    clear_logs();
    pulse_start(1'b1);
    wait_done(1'b1, 300);
    check("s2_busy_cycles", b_busy_cnt, 66);
    check("s2_w_count", b_wa_q.size(), 16);
    check("s2_if_count", b_ia_q.size(), 12);
    check("s2_wr_count", b_af_q.size(), 12);
    for (int i = 0; i < 16; i++) begin
      check("s2_w_addr", b_wa_q[i], i);
      check("s2_row_mask", b_rm_q[i], ((i / 4) % 2 == 0) ? 15 : 1);
    end
    for (int i = 0; i < 12; i++) begin
      check("s2_if_addr", b_ia_q[i], i % 6);
      check("s2_wr_first", b_af_q[i], ((i % 6) < 3) ? 1 : 0);
    end

    // Stall for two cycles at STREAM beat 1
    clear_logs();
    pulse_start(1'b0);
    wait_a_event(1'b0, 50);
    @(posedge clk); #1 stall = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 stall = 1'b0;
    wait_done(1'b0, 200);
    check("s3_busy_cycles", a_busy_cnt, 38);
    check("s3_if_gap01", a_ic_q[1] - a_ic_q[0], 3);
    check("s3_if_gap12", a_ic_q[2] - a_ic_q[1], 1);
    check("s3_wr_gap01", a_wc_q[1] - a_wc_q[0], 3);
    check_a_streams("s3");

    // Backpressure for three cycles in OUT
    clear_logs();
    pulse_start(1'b0);
    wait_a_event(1'b1, 100);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("s4_hold_addr", 32'(a_acc_rd_addr), 1);
    check("s4_hold_no_read", 32'(a_acc_rden), 0);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(1'b0, 200);
    check("s4_busy_cycles", a_busy_cnt, 39);
    check_a_streams("s4");

    // Reset during STREAM
    clear_logs();
    pulse_start(1'b0);
    wait_a_event(1'b0, 50);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("s5_outputs_zero", 32'(a_any), 0);
    clear_logs();
    repeat (12) @(negedge clk);
    check("s5_no_stale_writes", a_aw_q.size(), 0);
    check("s5_stays_idle", a_busy_cnt, 0);
    clear_logs();
    pulse_start(1'b0);
    wait_done(1'b0, 200);
    check("s5_restart_w_addr0", a_wa_q[0], 0);
    check("s5_restart_if_addr0", a_ia_q[0], 0);
    check("s5_busy_cycles", a_busy_cnt, 36);

    // start_i while busy is ignored
    clear_logs();
    pulse_start(1'b0);
    repeat (10) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done(1'b0, 200);
    repeat (5) @(negedge clk);
    check("s6_busy_cycles", a_busy_cnt, 36);
    check("s6_single_done", a_done_cnt, 1);
    check("s6_idle_after", 32'(a_busy), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
